// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared FSM state encoding and sizing helper for the adder BIST engine.
//   state_t      : 3-bit state encoding ST_IDLE..ST_DONE
//   settle_cnt_w : width of the settle counter for a given SETTLE
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Settle counter runs 0..SETTLE-1; keep at least one bit so SETTLE<2 still elaborates.
    function automatic int unsigned settle_cnt_w(input int unsigned settle);
        return (settle < 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/adder_bist_ref_add.sv
// bist_ref_add: reference adder producing the WIDTH+1-bit expected {cout,sum}.
//   i_a, i_b      : operands (WIDTH bits)
//   o_expected_c  : combinational i_a + i_b (WIDTH+1 bits)
module bist_ref_add #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_expected_c
);

    assign o_expected_c = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/adder_bist.sv
// adder_bist: exhaustive self-test engine for an external WIDTH-bit combinational adder.
// Drives every {b,a} combination, waits SETTLE cycles, compares {cout,sum} with a
// reference sum and reports a saturating error count plus a pass flag.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a run (honoured in IDLE or DONE only)
//   busy, done, pass   : run status; pass valid while done
//   err_cnt            : mismatching vectors, saturating at all-ones
//   dut_a, dut_b       : registered operands to the adder
//   dut_sum, dut_cout  : adder response
//   fail_a, fail_b     : first failing operands (only with ADDER_BIST_FIRST_FAIL_EN)
// Macro: ADDER_BIST_FIRST_FAIL_EN enables first-failure capture.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERRW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERRW-1:0]   err_cnt,
    output logic [WIDTH-1:0]  dut_a,
    output logic [WIDTH-1:0]  dut_b,
    input  logic [WIDTH-1:0]  dut_sum,
    input  logic              dut_cout
`ifdef ADDER_BIST_FIRST_FAIL_EN
    ,
    output logic [WIDTH-1:0]  fail_a,
    output logic [WIDTH-1:0]  fail_b
`endif
);

    localparam int unsigned    VW          = 2 * WIDTH;
    localparam int unsigned    CW          = settle_cnt_w(SETTLE);
    localparam logic [ERRW-1:0] ERR_SAT    = '1;
    localparam logic [CW-1:0]  SETTLE_LAST = CW'((SETTLE == 0) ? 0 : SETTLE - 1);

    state_t            r_state;
    logic [VW-1:0]     r_vec;
    logic [CW-1:0]     r_settle;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERRW-1:0]   r_err_cnt;
    logic [WIDTH-1:0]  r_dut_a;
    logic [WIDTH-1:0]  r_dut_b;

    logic [WIDTH:0]    w_expected;
    logic              w_mismatch;
    logic [ERRW-1:0]   w_err_next;

    bist_ref_add #(.WIDTH(WIDTH)) u_ref (
        .i_a          (r_dut_a),
        .i_b          (r_dut_b),
        .o_expected_c (w_expected)
    );

    // Error count as it will stand after the current CHECK cycle.
    assign w_mismatch = ({dut_cout, dut_sum} != w_expected);
    assign w_err_next = (w_mismatch && (r_err_cnt != ERR_SAT)) ? r_err_cnt + ERRW'(1) : r_err_cnt;

`ifdef ADDER_BIST_FIRST_FAIL_EN
    logic [WIDTH-1:0]  r_fail_a;
    logic [WIDTH-1:0]  r_fail_b;

    // err_cnt still zero means this is the run's first mismatch; it never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_a <= '0;
            r_fail_b <= '0;
        end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
            r_fail_a <= '0;
            r_fail_b <= '0;
        end else if (r_state == ST_CHECK && w_mismatch && r_err_cnt == '0) begin
            r_fail_a <= r_dut_a;
            r_fail_b <= r_dut_b;
        end
    end

    assign fail_a = r_fail_a;
    assign fail_b = r_fail_b;
`endif

    // Run sequencer: one DRIVE, SETTLE WAITs and one CHECK per vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec     <= '0;
            r_settle  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_dut_a   <= '0;
            r_dut_b   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_vec     <= '0;
                        r_err_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_dut_a  <= r_vec[WIDTH-1:0];
                    r_dut_b  <= r_vec[VW-1:WIDTH];
                    r_settle <= '0;
                    r_state  <= (SETTLE == 0) ? ST_CHECK : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle + CW'(1);
                    end
                end
                ST_CHECK: begin
                    r_err_cnt <= w_err_next;
                    if (&r_vec) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + VW'(1);
                        r_state <= ST_DRIVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
    assign dut_a   = r_dut_a;
    assign dut_b   = r_dut_b;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: self-checking bench for adder_bist.
// Four engines share clk/rst: u0 W=1 S=2, u1 W=2 S=1 ERRW=2, u2 W=1 S=0, u3 W=3 S=1 ERRW=4.
// Each drives a bench adder whose fault mode is selectable; u3 corrupts a random vector set.
module tb_adder_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] start_v = 4'b0;
    logic [3:0] busy_v, done_v, pass_v;
    int         mode_v [4];
    logic [7:0] err_x [4];
    logic [7:0] da_x [4];
    logic [7:0] db_x [4];
    logic [63:0] rmask = '0;

    int checks = 0;
    int errors = 0;

    // Bench adder: mode 0 good, 1 cout stuck 0, 2 sum stuck 0, 3 all outputs inverted.
    function automatic logic [8:0] adder_model(input int mode, input int w,
                                               input logic [7:0] a, input logic [7:0] b);
        logic [8:0] m;
        logic [8:0] full;
        logic [8:0] r;
        m    = (9'(1) << w) - 9'(1);
        full = m | (9'(1) << w);
        r    = (9'(a) + 9'(b)) & full;
        case (mode)
            1:       r = r & m;
            2:       r = r & ~m;
            3:       r = ~r & full;
            default: r = r;
        endcase
        return r;
    endfunction

    logic       e0_sum, e0_cout, a0, b0;
    logic [7:0] e0_err;
    logic [1:0] e1_sum, a1, b1;
    logic       e1_cout;
    logic [1:0] e1_err;
    logic       e2_sum, e2_cout, a2, b2;
    logic [7:0] e2_err;
    logic [2:0] e3_sum, a3, b3;
    logic       e3_cout;
    logic [3:0] e3_err;

    always_comb {e0_cout, e0_sum} = 2'(adder_model(mode_v[0], 1, 8'(a0), 8'(b0)));
    always_comb {e1_cout, e1_sum} = 3'(adder_model(mode_v[1], 2, 8'(a1), 8'(b1)));
    always_comb {e2_cout, e2_sum} = 2'(adder_model(mode_v[2], 1, 8'(a2), 8'(b2)));
    always_comb {e3_cout, e3_sum} = 4'(adder_model(0, 3, 8'(a3), 8'(b3)))
                                    ^ (rmask[{b3, a3}] ? 4'b1000 : 4'b0000);

    assign err_x[0] = 8'(e0_err); assign da_x[0] = 8'(a0); assign db_x[0] = 8'(b0);
    assign err_x[1] = 8'(e1_err); assign da_x[1] = 8'(a1); assign db_x[1] = 8'(b1);
    assign err_x[2] = 8'(e2_err); assign da_x[2] = 8'(a2); assign db_x[2] = 8'(b2);
    assign err_x[3] = 8'(e3_err); assign da_x[3] = 8'(a3); assign db_x[3] = 8'(b3);

`ifdef ADDER_BIST_FIRST_FAIL_EN
    logic       fa0, fb0, fa2, fb2;
    logic [1:0] fa1, fb1;
    logic [2:0] fa3, fb3;
    logic [7:0] fa_x [4];
    logic [7:0] fb_x [4];
    assign fa_x[0] = 8'(fa0); assign fb_x[0] = 8'(fb0);
    assign fa_x[1] = 8'(fa1); assign fb_x[1] = 8'(fb1);
    assign fa_x[2] = 8'(fa2); assign fb_x[2] = 8'(fb2);
    assign fa_x[3] = 8'(fa3); assign fb_x[3] = 8'(fb3);
`endif

    adder_bist #(.WIDTH(1), .SETTLE(2), .ERRW(8)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_cnt(e0_err), .dut_a(a0), .dut_b(b0),
        .dut_sum(e0_sum), .dut_cout(e0_cout)
`ifdef ADDER_BIST_FIRST_FAIL_EN
        , .fail_a(fa0), .fail_b(fb0)
`endif
    );

    adder_bist #(.WIDTH(2), .SETTLE(1), .ERRW(2)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_cnt(e1_err), .dut_a(a1), .dut_b(b1),
        .dut_sum(e1_sum), .dut_cout(e1_cout)
`ifdef ADDER_BIST_FIRST_FAIL_EN
        , .fail_a(fa1), .fail_b(fb1)
`endif
    );

    adder_bist #(.WIDTH(1), .SETTLE(0), .ERRW(8)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_cnt(e2_err), .dut_a(a2), .dut_b(b2),
        .dut_sum(e2_sum), .dut_cout(e2_cout)
`ifdef ADDER_BIST_FIRST_FAIL_EN
        , .fail_a(fa2), .fail_b(fb2)
`endif
    );

    adder_bist #(.WIDTH(3), .SETTLE(1), .ERRW(4)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .err_cnt(e3_err), .dut_a(a3), .dut_b(b3),
        .dut_sum(e3_sum), .dut_cout(e3_cout)
`ifdef ADDER_BIST_FIRST_FAIL_EN
        , .fail_a(fa3), .fail_b(fb3)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Start engine k, optionally hold start for `hold` extra edges, wait for done (bounded).
    task automatic run(input int k, input int s, input int hold, input int exp_len, input bit seq);
        int c;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        if (hold == 0) start_v[k] = 1'b0;
        chk("busy_rise", int'(busy_v[k]), 1);
        chk("done_clear", int'(done_v[k]), 0);
        c = 0;
        while (!done_v[k] && c < exp_len + 20) begin
            @(posedge clk); #1;
            c++;
            if (c >= hold) start_v[k] = 1'b0;
            if (seq && c <= exp_len && (c - 1) % (s + 2) == 0) begin
                chk("vec_a", int'(da_x[k]), ((c - 1) / (s + 2)) % 2);
                chk("vec_b", int'(db_x[k]), ((c - 1) / (s + 2)) / 2);
            end
        end
        chk("run_len", c, exp_len);
        chk("busy_fall", int'(busy_v[k]), 0);
    endtask

    typedef struct {
        int inst;
        int mode;
        int len;
        int exp_err;
        int exp_fa;
        int exp_fb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        for (int i = 0; i < 4; i++) mode_v[i] = 0;

        tbl[0] = '{0, 0, 16, 0, 0, 0};
        tbl[1] = '{0, 1, 16, 1, 1, 1};
        tbl[2] = '{0, 2, 16, 2, 1, 0};
        tbl[3] = '{0, 3, 16, 4, 0, 0};
        tbl[4] = '{1, 0, 48, 0, 0, 0};
        tbl[5] = '{1, 3, 48, 3, 0, 0};
        tbl[6] = '{1, 1, 48, 3, 3, 1};
        tbl[7] = '{1, 2, 48, 3, 1, 0};
        tbl[8] = '{2, 2, 8, 2, 1, 0};
        tbl[9] = '{2, 0, 8, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", int'(busy_v[k]), 0);
            chk("rst_done", int'(done_v[k]), 0);
            chk("rst_pass", int'(pass_v[k]), 0);
            chk("rst_err", int'(err_x[k]), 0);
            chk("rst_a", int'(da_x[k]) + int'(db_x[k]), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            mode_v[tbl[i].inst] = tbl[i].mode;
            run(tbl[i].inst, (tbl[i].inst == 0) ? 2 : (tbl[i].inst == 1) ? 1 : 0, 0,
                tbl[i].len, tbl[i].inst == 0 && tbl[i].mode == 0);
            chk("tbl_err", int'(err_x[tbl[i].inst]), tbl[i].exp_err);
            chk("tbl_pass", int'(pass_v[tbl[i].inst]), (tbl[i].exp_err == 0) ? 1 : 0);
            chk("tbl_done", int'(done_v[tbl[i].inst]), 1);
`ifdef ADDER_BIST_FIRST_FAIL_EN
            chk("tbl_fail_a", int'(fa_x[tbl[i].inst]), tbl[i].exp_fa);
            chk("tbl_fail_b", int'(fb_x[tbl[i].inst]), tbl[i].exp_fb);
`endif
        end

        // u2 sits in DONE: done/pass hold, then a rerun with a sum fault is reported afresh.
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", int'(done_v[2]), 1);
        chk("pass_hold", int'(pass_v[2]), 1);
        mode_v[2] = 1;
        run(2, 0, 0, 8, 1'b0);
        chk("rerun_err", int'(err_x[2]), 1);
        chk("rerun_pass", int'(pass_v[2]), 0);

        // Reset in the WAIT of vector 2 on u0 (inverted adder has already logged 2 errors).
        mode_v[0] = 3;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", int'(busy_v[0]), 1);
        chk("mid_err", int'(err_x[0]), 2);
        chk("mid_a", int'(da_x[0]), 0);
        chk("mid_b", int'(db_x[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_done", int'(done_v[0]), 0);
        chk("abort_err", int'(err_x[0]), 0);
        chk("abort_ab", int'(da_x[0]) + int'(db_x[0]), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy_v[0]), 0);
        chk("idle_done", int'(done_v[0]), 0);
        mode_v[0] = 0;
        run(0, 2, 3, 16, 1'b1);
        chk("held_start_err", int'(err_x[0]), 0);
        chk("held_start_pass", int'(pass_v[0]), 1);

        // Random fault sets on u3, checked against a population count of the corrupted set.
        for (int r = 0; r < 8; r++) begin
            int pct;
            int pop;
            int first;
            pct = (r == 0) ? 0 : int'($urandom_range(3, 40));
            for (int v = 0; v < 64; v++) rmask[v] = ($urandom_range(0, 99) < pct);
            pop = 0;
            first = -1;
            for (int v = 0; v < 64; v++) begin
                if (rmask[v]) begin
                    pop++;
                    if (first < 0) first = v;
                end
            end
            run(3, 1, 0, 192, 1'b0);
            chk("rnd_err", int'(err_x[3]), (pop > 15) ? 15 : pop);
            chk("rnd_pass", int'(pass_v[3]), (pop == 0) ? 1 : 0);
`ifdef ADDER_BIST_FIRST_FAIL_EN
            chk("rnd_fail_a", int'(fa_x[3]), (first < 0) ? 0 : first % 8);
            chk("rnd_fail_b", int'(fb_x[3]), (first < 0) ? 0 : first / 8);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
